fp32_sink: RTL
==============

# fp32_sink

Testbench result sink for the fp32 adder: the consuming end of the stimulus stream. It captures each accepted operand pair (x1, x2) into an in-order FIFO and pairs it with the adder's next result. Each result is checked against exact IEEE-754 special-case rules, with results and errors counted. A pass/done verdict is raised after the stimulus ends and the pipeline drains.

## Interface
Parameters:
- DEPTH, 16: operand FIFO entries (power of two, ≥ adder latency + 1).
- TIMEOUT, 1024: idle cycles allowed while results are outstanding.
- DRAIN_IDLE, 64: consecutive empty/idle cycles in DRAIN before done.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- x1  in  32  operand A from stimulus source.
- x2  in  32  operand B from stimulus source.
- op_val  in  1  operand pair valid.
- op_over  in  1  stimulus end (level, may stay high).
- sum  in  32  adder result.
- sum_val  in  1  result valid (in operand order).
- err_valid  out  1  one-cycle pulse per failed check.
- err_x1, err_x2, err_sum  out  32  offending operands/result; held until next error.
- n_results  out  32  results consumed.
- n_errors  out  32  failed checks plus protocol errors.
- n_unchecked  out  32  results matching no exact rule.
- done  out  1  verdict valid (sticky).
- pass  out  1  1 iff done and n_errors == 0.

## Operation
- Reset: all outputs 0, FIFO empty, state IDLE, counters 0.
- States: IDLE → RUN on first accepted operand; RUN → DRAIN when op_over is first seen high; DRAIN → DONE when the FIFO stays empty and sum_val stays 0 for DRAIN_IDLE consecutive cycles; DONE is terminal until rst.
- Accept: op_val=1 in IDLE/RUN, or in the cycle op_over first rises (that pair is the last one). No accepts in DRAIN/DONE, even though op_val stays high.
- Push on accept; pop head on sum_val. Simultaneous push and pop is legal at any occupancy, including full.
- Full and push with no pop: pair dropped, n_errors += 1, err pulse carrying the dropped pair and sum=0.
- sum_val with FIFO empty: n_errors += 1, err pulse with x1=x2=0 and the received sum.
- Rules, applied in priority order to head pair (a, b) and result s:
  1. Either input NaN → s must be NaN (exp=FF, mant≠0).
  2. +inf with −inf → s NaN.
  3. Exactly one inf, or both the same inf → s == that inf, bitwise.
  4. Both ±0 → s == 0x80000000 if both −0, else 0x00000000.
  5. One input ±0 and the other normal → s == the normal operand, bitwise.
  6. a == b ^ 0x80000000, finite → s == 0x00000000.
  7. Otherwise → s must not be NaN or inf if both exponents < FE; else unchecked. Increment n_unchecked when no rule gives an exact value and the result is not already an error.
- n_results += 1 per popped result. Counters saturate at 0xFFFFFFFF.
- Timeout: in RUN/DRAIN, if the FIFO is non-empty and sum_val stays 0 for TIMEOUT cycles, n_errors += 1 once, FIFO flushed, and the timeout counter restarts.

## Timing
- Check is registered: err_valid and counter updates occur 1 cycle after the sum_val cycle.
- The push is visible for a pop in the next cycle. Minimum adder latency supported: 1.
- done and pass rise together, the cycle after the DRAIN_IDLE-th idle cycle.
- rst mid-run: next cycle returns to reset values. Operands and results in flight are discarded.
- DONE with a stray sum_val: counted as a protocol error (n_errors += 1, err pulse), and pass drops.

## Structure
- Package fp32_sink_pkg: class enum (ZERO, SUB, NORM, INF, NAN), state enum (IDLE, RUN, DRAIN, DONE), constants POS_ZERO, NEG_ZERO, POS_INF, NEG_INF, EXP_MAX=8'hFF, and a classify function.
- Sub-module sync_fifo (WIDTH=64, DEPTH): synchronous FIFO with full/empty and simultaneous read/write. Rule checking and the FSM stay in fp32_sink.

## Test plan
- Push 3F800000+BF800000, then sum 00000000 two cycles later → no error, n_results=1, n_unchecked=0.
- 7F800000+FF800000 with sum 7F800000 → err_valid pulse, err_sum=7F800000, n_errors=1, pass=0 at done.
- 7FC00000+3F800000 with sum 7FC00001 → accepted (NaN); 00000000+40490FDB with sum 40490FDB → accepted; then op_over → done=1, pass=1.
- DEPTH+1 pushes with no sum_val → n_errors=1 (overflow). After TIMEOUT more cycles, n_errors=2 and the FIFO is empty.
- op_over held high with op_val=1 for 100 cycles → exactly one pair accepted. After its result and DRAIN_IDLE idle cycles, done=1.
- rst asserted one cycle with 5 pairs outstanding → all outputs 0 next cycle. A subsequent sum_val counts as an underflow error.

Source files
------------

// File: rtl/fp32_sink_pkg.sv
// fp32_sink_pkg: shared types, constants and helpers
// for the fp32 adder result sink.
package fp32_sink_pkg;

  typedef enum logic [2:0] {
    ZERO, SUB, NORM, INF, NAN
  } fp_class_e;

  typedef enum logic [1:0] {
    IDLE, RUN, DRAIN, DONE
  } state_e;

  localparam logic [31:0] POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] NEG_ZERO = 32'h8000_0000;
  localparam logic [31:0] POS_INF  = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF  = 32'hFF80_0000;
  localparam logic [7:0]  EXP_MAX  = 8'hFF;

  function automatic fp_class_e classify(
    input logic [31:0] v
  );
    logic [7:0]  e;
    logic [22:0] m;
    e = v[30:23];
    m = v[22:0];
    if (e == EXP_MAX)
      return (m == '0) ? INF : NAN;
    if (e == '0)
      return (m == '0) ? ZERO : SUB;
    return NORM;
  endfunction

  // Counters stick at all-ones instead
  // of wrapping.
  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic [2:0]  b
  );
    logic [32:0] t;
    t = {1'b0, a} + {30'd0, b};
    return t[32] ? '1 : t[31:0];
  endfunction

endpackage

// File: rtl/fp32_sink_if.sv
// fp32_sink_if: operand stream and adder result bus.
// master drives x1/x2/op_val/op_over/sum/sum_val, slave samples.
interface fp32_sink_if;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        op_val;
  logic        op_over;
  logic [31:0] sum;
  logic        sum_val;

  modport master (
    output x1, x2, op_val, op_over,
    output sum, sum_val
  );

  modport slave (
    input x1, x2, op_val, op_over,
    input sum, sum_val
  );
endinterface

// File: rtl/fp32_sink_sync_fifo.sv
// sync_fifo: single-clock FIFO, simultaneous read/write at any level.
// Ports: clk, rst, i_wr/i_wdata, i_rd, i_flush, o_rdata, o_full, o_empty.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_rd,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [CW-1:0]    r_cnt;

  assign o_full  = (r_cnt == FULL_CNT);
  assign o_empty = (r_cnt == '0);
  assign o_rdata = r_mem[r_rp];

  always_ff @(posedge clk) begin
    if (i_wr)
      r_mem[r_wp] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      // A write landing with the flush survives
      // as the only entry.
      r_rp  <= r_wp;
      r_wp  <= r_wp + AW'(i_wr);
      r_cnt <= CW'(i_wr);
    end else begin
      if (i_wr)
        r_wp <= r_wp + 1'b1;
      if (i_rd)
        r_rp <= r_rp + 1'b1;
      unique case ({i_wr, i_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/fp32_sink.sv
// fp32_sink: pairs each accepted operand pair with the adder's next result,
// checks IEEE-754 special cases, counts results/errors and gives a verdict.
// Ports: clk, rst, bus (slave), err_valid/err_x1/err_x2/err_sum,
// n_results, n_errors, n_unchecked, done, pass.
module fp32_sink
  import fp32_sink_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int TIMEOUT    = 1024,
  parameter int DRAIN_IDLE = 64
) (
  input  logic        clk,
  input  logic        rst,
  fp32_sink_if.slave  bus,
  output logic        err_valid,
  output logic [31:0] err_x1,
  output logic [31:0] err_x2,
  output logic [31:0] err_sum,
  output logic [31:0] n_results,
  output logic [31:0] n_errors,
  output logic [31:0] n_unchecked,
  output logic        done,
  output logic        pass
);
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam int DI_W = $clog2(DRAIN_IDLE + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [DI_W-1:0] DI_LAST = DI_W'(DRAIN_IDLE - 1);
  localparam logic [7:0] EXP_BIG = EXP_MAX - 8'd1;

  state_e          r_state;
  logic [TO_W-1:0] r_to_cnt;
  logic [DI_W-1:0] r_idle_cnt;
  logic            r_err_valid;
  logic [31:0]     r_err_x1;
  logic [31:0]     r_err_x2;
  logic [31:0]     r_err_sum;
  logic [31:0]     r_n_results;
  logic [31:0]     r_n_errors;
  logic [31:0]     r_n_unchecked;
  logic            r_done;
  logic            r_pass;

  logic [63:0] w_head;
  logic        w_full;
  logic        w_empty;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [31:0] w_s;
  fp_class_e   w_ca;
  fp_class_e   w_cb;
  fp_class_e   w_cs;
  logic        w_s_nan;
  logic        w_s_inf;
  logic        w_ok;
  logic        w_exact;

  logic w_accept;
  logic w_pop;
  logic w_push;
  logic w_ovf;
  logic w_unf;
  logic w_to_act;
  logic w_timeout;
  logic w_idle;
  logic w_to_done;
  logic w_chk_fail;
  logic w_unchk;
  logic w_err;
  logic [2:0]  w_err_inc;
  logic [31:0] w_nerr_next;
  logic [31:0] w_ex1;
  logic [31:0] w_ex2;
  logic [31:0] w_esum;

  assign w_accept = bus.op_val
                  && (r_state == IDLE || r_state == RUN);
  assign w_pop    = bus.sum_val && !w_empty;
  assign w_ovf    = w_accept && w_full && !w_pop;
  assign w_push   = w_accept && !w_ovf;
  assign w_unf    = bus.sum_val && w_empty;
  assign w_to_act = (r_state == RUN || r_state == DRAIN)
                  && !w_empty && !bus.sum_val;
  assign w_timeout = w_to_act && (r_to_cnt == TO_LAST);
  assign w_idle    = w_empty && !bus.sum_val;
  assign w_to_done = (r_state == DRAIN) && w_idle
                   && (r_idle_cnt == DI_LAST);

  sync_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_wr    (w_push),
    .i_wdata ({bus.x1, bus.x2}),
    .i_rd    (w_pop),
    .i_flush (w_timeout),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_a  = w_head[63:32];
  assign w_b  = w_head[31:0];
  assign w_s  = bus.sum;
  assign w_ca = classify(w_a);
  assign w_cb = classify(w_b);
  assign w_cs = classify(w_s);
  assign w_s_nan = (w_cs == NAN);
  assign w_s_inf = (w_cs == INF);

  // First matching rule wins; only the
  // catch-all leaves the result unchecked.
  always_comb begin
    w_ok    = 1'b1;
    w_exact = 1'b1;
    if (w_ca == NAN || w_cb == NAN)
      w_ok = w_s_nan;
    else if (w_ca == INF && w_cb == INF
             && w_a[31] != w_b[31])
      w_ok = w_s_nan;
    else if (w_ca == INF)
      w_ok = (w_s == w_a);
    else if (w_cb == INF)
      w_ok = (w_s == w_b);
    else if (w_ca == ZERO && w_cb == ZERO)
      w_ok = (w_s == ((w_a[31] && w_b[31])
                      ? NEG_ZERO : POS_ZERO));
    else if (w_ca == ZERO && w_cb == NORM)
      w_ok = (w_s == w_b);
    else if (w_cb == ZERO && w_ca == NORM)
      w_ok = (w_s == w_a);
    else if (w_a == (w_b ^ NEG_ZERO))
      w_ok = (w_s == POS_ZERO);
    else begin
      w_exact = 1'b0;
      if (w_a[30:23] < EXP_BIG
          && w_b[30:23] < EXP_BIG)
        w_ok = !(w_s_nan || w_s_inf);
    end
  end

  assign w_chk_fail = w_pop && !w_ok;
  assign w_unchk    = w_pop && w_ok && !w_exact;
  assign w_err      = w_ovf || w_unf || w_chk_fail;
  assign w_err_inc  = {2'b0, w_ovf} + {2'b0, w_unf}
                    + {2'b0, w_chk_fail}
                    + {2'b0, w_timeout};
  assign w_nerr_next = sat_add(r_n_errors, w_err_inc);

  assign w_ex1  = w_ovf ? bus.x1
                : (w_unf ? '0 : w_a);
  assign w_ex2  = w_ovf ? bus.x2
                : (w_unf ? '0 : w_b);
  assign w_esum = w_ovf ? '0 : w_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_to_cnt      <= '0;
      r_idle_cnt    <= '0;
      r_err_valid   <= 1'b0;
      r_err_x1      <= '0;
      r_err_x2      <= '0;
      r_err_sum     <= '0;
      r_n_results   <= '0;
      r_n_errors    <= '0;
      r_n_unchecked <= '0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
    end else begin
      r_err_valid <= w_err;
      if (w_err) begin
        r_err_x1  <= w_ex1;
        r_err_x2  <= w_ex2;
        r_err_sum <= w_esum;
      end
      r_n_results <= sat_add(r_n_results,
                             {2'b0, w_pop});
      r_n_errors  <= w_nerr_next;
      r_n_unchecked <= sat_add(r_n_unchecked,
                               {2'b0, w_unchk});
      r_to_cnt <= (w_to_act && !w_timeout)
                  ? r_to_cnt + 1'b1 : '0;
      r_pass <= (r_done || w_to_done)
                && (w_nerr_next == '0);
      unique case (r_state)
        IDLE: begin
          if (bus.op_over)
            r_state <= DRAIN;
          else if (bus.op_val)
            r_state <= RUN;
        end
        RUN: begin
          if (bus.op_over)
            r_state <= DRAIN;
        end
        DRAIN: begin
          if (!w_idle)
            r_idle_cnt <= '0;
          else if (w_to_done) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
        DONE:    r_done  <= 1'b1;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign err_valid   = r_err_valid;
  assign err_x1      = r_err_x1;
  assign err_x2      = r_err_x2;
  assign err_sum     = r_err_sum;
  assign n_results   = r_n_results;
  assign n_errors    = r_n_errors;
  assign n_unchecked = r_n_unchecked;
  assign done        = r_done;
  assign pass        = r_pass;
endmodule
